// File: rtl/fetch_unit_pkg.sv
// Shared fetch-stage definitions: FSM state encodings and default widths/reset PC.
`timescale 1ns/1ps
package fetch_unit_pkg;

  localparam int unsigned PC_WIDTH_DEF   = 32;
  localparam int unsigned INST_WIDTH_DEF = 32;
  localparam logic [31:0] RESET_PC_DEF   = 32'h0000_0000;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_REQ  = 3'd1,
    ST_WAIT = 3'd2,
    ST_HOLD = 3'd3,
    ST_DROP = 3'd4
  } fetch_state_e;

endpackage

// File: rtl/fetch_pc_reg.sv
// Program counter: redirect beats advance; the +4 adder wraps naturally at PC_WIDTH.
`timescale 1ns/1ps
module fetch_pc_reg #(
  parameter int unsigned         PC_WIDTH = 32,
  parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                i_redirect,
  input  logic [PC_WIDTH-1:0] i_target,
  input  logic                i_advance,
  output logic [PC_WIDTH-1:0] o_pc,
  output logic [PC_WIDTH-1:0] o_pc_next
);

  logic [PC_WIDTH-1:0] r_pc;
  logic [PC_WIDTH-1:0] w_pc_plus4;
  logic [PC_WIDTH-1:0] w_target_aligned;

  assign w_pc_plus4       = r_pc + PC_WIDTH'(4);
  // Branch targets are word-aligned regardless of what the later stage sends.
  assign w_target_aligned = i_target & ~PC_WIDTH'(3);

  // PC update: redirect has priority over sequential advance.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)        r_pc <= RESET_PC;
    else if (i_redirect) r_pc <= w_target_aligned;
    else if (i_advance)  r_pc <= w_pc_plus4;
  end

  assign o_pc      = r_pc;
  assign o_pc_next = w_pc_plus4;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: one outstanding imem request, single-entry instruction buffer,
// redirect handling that drops in-flight responses.
`timescale 1ns/1ps
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int unsigned         PC_WIDTH   = PC_WIDTH_DEF,
  parameter int unsigned         INST_WIDTH = INST_WIDTH_DEF,
  parameter logic [PC_WIDTH-1:0] RESET_PC   = PC_WIDTH'(RESET_PC_DEF)
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  branch_taken,
  input  logic [PC_WIDTH-1:0]   branch_target,
  input  logic                  IF_ID_write,
  output logic                  imem_req,
  output logic [PC_WIDTH-1:0]   imem_addr,
  input  logic                  imem_gnt,
  input  logic                  imem_rvalid,
  input  logic [INST_WIDTH-1:0] imem_rdata,
  output logic                  fetch_valid,
  output logic [PC_WIDTH-1:0]   fetch_pc,
  output logic [PC_WIDTH-1:0]   fetch_pc_next,
  output logic [INST_WIDTH-1:0] fetch_inst,
  output logic                  IF_flush
);

  fetch_state_e          r_state;
  logic [INST_WIDTH-1:0] r_buf;
  logic                  r_imem_req;
  logic                  r_fetch_valid;
  logic                  w_accept;
  logic                  w_advance;
  logic [PC_WIDTH-1:0]   w_pc;
  logic [PC_WIDTH-1:0]   w_pc_next;

  // r_imem_req is high exactly while in ST_REQ.
  assign w_accept  = r_imem_req & imem_gnt;
  assign w_advance = (r_state == ST_HOLD) & IF_ID_write & ~branch_taken;

  fetch_pc_reg #(
    .PC_WIDTH (PC_WIDTH),
    .RESET_PC (RESET_PC)
  ) u_pc (
    .clk        (clk),
    .reset_n    (reset_n),
    .i_redirect (branch_taken),
    .i_target   (branch_target),
    .i_advance  (w_advance),
    .o_pc       (w_pc),
    .o_pc_next  (w_pc_next)
  );

  // Fetch FSM with registered request/valid flags and the instruction buffer.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= ST_IDLE;
      r_buf         <= '0;
      r_imem_req    <= 1'b0;
      r_fetch_valid <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_state    <= ST_REQ;
          r_imem_req <= 1'b1;
        end
        ST_REQ: begin
          // Without accept we stay; the address follows pc, so a redirect just retargets.
          if (w_accept) begin
            r_state    <= branch_taken ? ST_DROP : ST_WAIT;
            r_imem_req <= 1'b0;
          end
        end
        ST_WAIT: begin
          if (branch_taken) begin
            // A response landing with the redirect is stale; otherwise wait it out in DROP.
            r_state    <= imem_rvalid ? ST_REQ : ST_DROP;
            r_imem_req <= imem_rvalid;
          end else if (imem_rvalid) begin
            r_state       <= ST_HOLD;
            r_buf         <= imem_rdata;
            r_fetch_valid <= 1'b1;
          end
        end
        ST_HOLD: begin
          if (branch_taken || IF_ID_write) begin
            r_state       <= ST_REQ;
            r_imem_req    <= 1'b1;
            r_fetch_valid <= 1'b0;
            r_buf         <= '0;
          end
        end
        ST_DROP: begin
          // Redirects here only move pc (handled in u_pc); the pending response is discarded.
          if (imem_rvalid) begin
            r_state    <= ST_REQ;
            r_imem_req <= 1'b1;
          end
        end
        default: begin
          r_state       <= ST_IDLE;
          r_imem_req    <= 1'b0;
          r_fetch_valid <= 1'b0;
        end
      endcase
    end
  end

  assign imem_req      = r_imem_req;
  assign imem_addr     = w_pc;
  assign fetch_valid   = r_fetch_valid;
  assign fetch_pc      = w_pc;
  assign fetch_pc_next = w_pc_next;
  assign fetch_inst    = r_fetch_valid ? r_buf : '0;
  assign IF_flush      = branch_taken;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: memory responder, scoreboard of expected fetches, scenario tasks.
`timescale 1ns/1ps
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        branch_taken = 1'b0;
  logic [31:0] branch_target = '0;
  logic        IF_ID_write = 1'b0;
  logic        imem_gnt = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        fetch_valid;
  logic [31:0] fetch_pc;
  logic [31:0] fetch_pc_next;
  logic [31:0] fetch_inst;
  logic        IF_flush;

  fetch_unit dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .IF_ID_write   (IF_ID_write),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_gnt      (imem_gnt),
    .imem_rvalid   (imem_rvalid),
    .imem_rdata    (imem_rdata),
    .fetch_valid   (fetch_valid),
    .fetch_pc      (fetch_pc),
    .fetch_pc_next (fetch_pc_next),
    .fetch_inst    (fetch_inst),
    .IF_flush      (IF_flush)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
  } exp_t;
  exp_t sb[$];

  int          rsp_delay = 1;
  int          rsp_cnt = 0;
  logic [31:0] rsp_addr = '0;

  function automatic logic [31:0] memf(input logic [31:0] a);
    return a ^ 32'hC0DE_0000;
  endfunction

  function automatic void push_exp(input logic [31:0] pc);
    exp_t e;
    e.pc   = pc;
    e.inst = memf(pc);
    sb.push_back(e);
  endfunction

  // Memory model: answers each accepted request rsp_delay cycles later; keeps going across reset.
  initial forever begin
    @(negedge clk);
    #1;
    if (rsp_cnt > 0) begin
      rsp_cnt--;
      if (rsp_cnt == 0) begin
        imem_rvalid = 1'b1;
        imem_rdata  = memf(rsp_addr);
      end else imem_rvalid = 1'b0;
    end else imem_rvalid = 1'b0;
    if (imem_req === 1'b1 && imem_gnt === 1'b1) begin
      rsp_addr = imem_addr;
      rsp_cnt  = rsp_delay;
    end
  end

  // Monitor: each new valid instruction is checked against the scoreboard head.
  logic prev_v = 1'b0;
  initial forever begin
    exp_t e;
    @(negedge clk);
    #2;
    vectors++;
    if (fetch_valid === 1'b0 && fetch_inst !== 32'h0) begin
      miscompares++;
      $display("FAIL inst_zero: fetch_inst=%h while invalid, want 0", fetch_inst);
    end
    if (fetch_valid === 1'b1 && !prev_v) begin
      vectors++;
      if (sb.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_fetch: pc=%h inst=%h, want none", fetch_pc, fetch_inst);
      end else begin
        e = sb.pop_front();
        if (fetch_pc !== e.pc || fetch_inst !== e.inst || fetch_pc_next !== e.pc + 32'd4) begin
          miscompares++;
          $display("FAIL fetch_sb: pc=%h inst=%h nxt=%h, want pc=%h inst=%h nxt=%h",
                   fetch_pc, fetch_inst, fetch_pc_next, e.pc, e.inst, e.pc + 32'd4);
        end
      end
    end
    prev_v = (fetch_valid === 1'b1);
  end

  task automatic wait_valid(input int n, input string tag);
    int k = 0;
    while (fetch_valid !== 1'b1 && k < n) begin
      @(negedge clk);
      k++;
    end
    vectors++;
    if (fetch_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL %s: fetch_valid timeout got %b want 1", tag, fetch_valid);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    vectors++;
    if (imem_req !== 1'b0 || fetch_valid !== 1'b0 || fetch_inst !== 32'h0 ||
        fetch_pc !== 32'h0 || fetch_pc_next !== 32'h4 || IF_flush !== 1'b0) begin
      miscompares++;
      $display("FAIL reset: req=%b v=%b inst=%h pc=%h nxt=%h flush=%b, want 0 0 0 0 4 0",
               imem_req, fetch_valid, fetch_inst, fetch_pc, fetch_pc_next, IF_flush);
    end
  endtask

  // Zero-wait stream: one instruction every 3 cycles at 0x0, 0x4, 0x8.
  task automatic test_stream();
    rsp_delay = 1;
    imem_gnt = 1'b1;
    IF_ID_write = 1'b1;
    push_exp(32'h0); push_exp(32'h4); push_exp(32'h8);
    reset_n = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 9; i++) begin
      logic        er, ev;
      logic [31:0] ea;
      er = (i % 3 == 0);
      ev = (i % 3 == 2);
      ea = 32'(4 * (i / 3));
      vectors++;
      if (imem_req !== er || (er && imem_addr !== ea) || fetch_valid !== ev || (ev && fetch_pc !== ea)) begin
        miscompares++;
        $display("FAIL stream[%0d]: req=%b addr=%h v=%b pc=%h, want req=%b addr=%h v=%b",
                 i, imem_req, imem_addr, fetch_valid, fetch_pc, er, ea, ev);
      end
      if (i < 8) @(negedge clk);
    end
    IF_ID_write = 1'b0;
  endtask

  task automatic test_stall();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      vectors++;
      if (fetch_valid !== 1'b1 || fetch_pc !== 32'h8 || fetch_inst !== memf(32'h8) || imem_req !== 1'b0) begin
        miscompares++;
        $display("FAIL stall[%0d]: v=%b pc=%h inst=%h req=%b, want 1 00000008 %h 0",
                 i, fetch_valid, fetch_pc, fetch_inst, imem_req, memf(32'h8));
      end
    end
    IF_ID_write = 1'b1;
    @(negedge clk);
    IF_ID_write = 1'b0;
    vectors++;
    if (imem_req !== 1'b1 || imem_addr !== 32'hC) begin
      miscompares++;
      $display("FAIL stall_release: req=%b addr=%h, want 1 0000000c", imem_req, imem_addr);
    end
  endtask

  // Redirect during WAIT: response for 0xC dropped, refetch at aligned 0x100.
  task automatic test_branch_wait();
    rsp_delay = 3;
    @(negedge clk);
    branch_taken = 1'b1;
    branch_target = 32'h103;
    #1;
    vectors++;
    if (imem_req !== 1'b0 || IF_flush !== 1'b1) begin
      miscompares++;
      $display("FAIL bw_flush: req=%b flush=%b, want 0 1", imem_req, IF_flush);
    end
    @(negedge clk);
    branch_taken = 1'b0;
    #1;
    vectors++;
    if (imem_req !== 1'b0 || IF_flush !== 1'b0) begin
      miscompares++;
      $display("FAIL bw_drop: req=%b flush=%b, want 0 0", imem_req, IF_flush);
    end
    @(negedge clk);
    vectors++;
    if (imem_req !== 1'b0 || fetch_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL bw_drop2: req=%b v=%b, want 0 0", imem_req, fetch_valid);
    end
    rsp_delay = 1;
    push_exp(32'h100);
    @(negedge clk);
    vectors++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h100 || fetch_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL bw_refetch: req=%b addr=%h v=%b, want 1 00000100 0", imem_req, imem_addr, fetch_valid);
    end
    wait_valid(10, "bw_wait");
  endtask

  task automatic test_wrap();
    push_exp(32'hFFFF_FFFC);
    branch_taken = 1'b1;
    branch_target = 32'hFFFF_FFFC;
    @(negedge clk);
    branch_taken = 1'b0;
    vectors++;
    if (imem_req !== 1'b1 || imem_addr !== 32'hFFFF_FFFC || fetch_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL wrap_req: req=%b addr=%h v=%b, want 1 fffffffc 0", imem_req, imem_addr, fetch_valid);
    end
    wait_valid(10, "wrap_wait");
    vectors++;
    if (fetch_pc_next !== 32'h0) begin
      miscompares++;
      $display("FAIL wrap_next: fetch_pc_next=%h, want 00000000", fetch_pc_next);
    end
    push_exp(32'h0);
    IF_ID_write = 1'b1;
    @(negedge clk);
    IF_ID_write = 1'b0;
    vectors++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
      miscompares++;
      $display("FAIL wrap_addr: req=%b addr=%h, want 1 00000000", imem_req, imem_addr);
    end
    wait_valid(10, "wrap_wait2");
  endtask

  task automatic test_branch_consume();
    push_exp(32'h40);
    IF_ID_write = 1'b1;
    branch_taken = 1'b1;
    branch_target = 32'h40;
    @(negedge clk);
    IF_ID_write = 1'b0;
    branch_taken = 1'b0;
    vectors++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h40 || fetch_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL bc_req: req=%b addr=%h v=%b, want 1 00000040 0", imem_req, imem_addr, fetch_valid);
    end
    wait_valid(10, "bc_wait");
  endtask

  // Ungranted request follows redirects; redirect coincident with accept goes via DROP.
  task automatic test_redirect_req();
    imem_gnt = 1'b0;
    IF_ID_write = 1'b1;
    @(negedge clk);
    IF_ID_write = 1'b0;
    for (int i = 0; i < 2; i++) begin
      vectors++;
      if (imem_req !== 1'b1 || imem_addr !== 32'h44) begin
        miscompares++;
        $display("FAIL rr_nogrant[%0d]: req=%b addr=%h, want 1 00000044", i, imem_req, imem_addr);
      end
      if (i == 0) @(negedge clk);
    end
    branch_taken = 1'b1;
    branch_target = 32'h200;
    @(negedge clk);
    vectors++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h200) begin
      miscompares++;
      $display("FAIL rr_retarget: req=%b addr=%h, want 1 00000200", imem_req, imem_addr);
    end
    branch_target = 32'h300;
    imem_gnt = 1'b1;
    @(negedge clk);
    branch_taken = 1'b0;
    vectors++;
    if (imem_req !== 1'b0) begin
      miscompares++;
      $display("FAIL rr_drop: req=%b, want 0", imem_req);
    end
    push_exp(32'h300);
    @(negedge clk);
    vectors++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h300 || fetch_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL rr_refetch: req=%b addr=%h v=%b, want 1 00000300 0", imem_req, imem_addr, fetch_valid);
    end
    wait_valid(10, "rr_wait");
  endtask

  // Reset while waiting; the stale response arrives after release and must be ignored.
  task automatic test_reset_mid();
    rsp_delay = 3;
    IF_ID_write = 1'b1;
    @(negedge clk);
    IF_ID_write = 1'b0;
    vectors++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h304) begin
      miscompares++;
      $display("FAIL rm_req: req=%b addr=%h, want 1 00000304", imem_req, imem_addr);
    end
    @(negedge clk);
    reset_n = 1'b0;
    imem_gnt = 1'b0;
    #1;
    vectors++;
    if (imem_req !== 1'b0 || fetch_valid !== 1'b0 || fetch_pc !== 32'h0) begin
      miscompares++;
      $display("FAIL rm_rst: req=%b v=%b pc=%h, want 0 0 00000000", imem_req, fetch_valid, fetch_pc);
    end
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      vectors++;
      if (imem_req !== 1'b1 || imem_addr !== 32'h0 || fetch_valid !== 1'b0) begin
        miscompares++;
        $display("FAIL rm_stale[%0d]: req=%b addr=%h v=%b, want 1 00000000 0", i, imem_req, imem_addr, fetch_valid);
      end
    end
    rsp_delay = 1;
    push_exp(32'h0);
    imem_gnt = 1'b1;
    wait_valid(10, "rm_wait");
  endtask

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_branch_wait();
    test_wrap();
    test_branch_consume();
    test_redirect_req();
    test_reset_mid();
    repeat (2) @(negedge clk);
    vectors++;
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL sb_drain: %0d expected fetches left, want 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter PC_WIDTH, default `PC_WIDTH (32), program-counter width.
REQ-002 Parameter INST_WIDTH, default `INST_WIDTH (32), instruction width.
REQ-003 Parameter RESET_PC, default 32'h0000_0000, first fetch address.
REQ-004 clk  input  1  single clock; all state changes on rising edge.
REQ-005 reset_n  input  1  asynchronous, active-low reset.
REQ-006 branch_taken  input  1  redirect request from later stage.
REQ-007 branch_target  input  PC_WIDTH  redirect address.
REQ-008 IF_ID_write  input  1  downstream IF/ID accepts current fetch output.
REQ-009 imem_req  output  1  instruction-memory request.
REQ-010 imem_addr  output  PC_WIDTH  request address.
REQ-011 imem_gnt  input  1  request accepted when imem_req && imem_gnt.
REQ-012 imem_rvalid  input  1  response valid, at least 1 cycle after acceptance.
REQ-013 imem_rdata  input  INST_WIDTH  response instruction.
REQ-014 fetch_valid  output  1  fetch_inst/fetch_pc hold a valid instruction.
REQ-015 fetch_pc, fetch_pc_next  output  PC_WIDTH each  instruction PC and PC+4.
REQ-016 fetch_inst  output  INST_WIDTH  buffered instruction; 0 when fetch_valid=0.
REQ-017 IF_flush  output  1  combinational copy of branch_taken, drives IF/ID flush.

Function
REQ-018 States: IDLE, REQ, WAIT, HOLD, DROP; at most one outstanding memory request.
REQ-019 IDLE: entered only from reset; unconditionally REQ next cycle.
REQ-020 REQ: imem_req=1, imem_addr=pc; on accept -> WAIT; otherwise stay.
REQ-021 WAIT: imem_req=0; on imem_rvalid capture imem_rdata into buffer -> HOLD.
REQ-022 HOLD: fetch_valid=1, fetch_inst=buffer, fetch_pc=pc, fetch_pc_next=pc+4; outputs stable until consumed.
REQ-023 HOLD with IF_ID_write=1: consumed at that edge, pc<=pc+4, buffer invalidated, -> REQ.
REQ-024 Latency: fetch_valid rises the cycle after imem_rvalid; minimum 3 cycles per instruction with zero-wait memory.
REQ-025 pc+4 wraps modulo 2^PC_WIDTH; branch_target[1:0] forced to 0.
REQ-026 Redirect has highest priority: pc<=target, buffer invalidated, fetch_valid=0 next cycle.
REQ-027 Redirect in IDLE, HOLD, or REQ without accept -> REQ at target (address may change while ungranted).
REQ-028 Redirect in REQ with accept, or in WAIT without imem_rvalid -> DROP.
REQ-029 Redirect in WAIT coincident with imem_rvalid: response discarded -> REQ.
REQ-030 DROP: imem_req=0; next imem_rvalid discarded -> REQ; further redirect in DROP updates pc, stays DROP.
REQ-031 Redirect in HOLD coincident with IF_ID_write: redirect wins, pc<=target, no pc+4.
REQ-032 imem_rvalid outside WAIT/DROP ignored.

Reset
REQ-033 reset_n low: state=IDLE, pc=RESET_PC, buffer=0, fetch_valid=0, imem_req=0, fetch_inst=0, fetch_pc=RESET_PC, fetch_pc_next=RESET_PC+4.
REQ-034 Reset mid-request abandons the outstanding transaction; any later stale imem_rvalid falls under REQ-032.

Structure
REQ-035 State encodings and RESET_PC default in shared risc_v_defines.vh.
REQ-036 One sub-module, fetch_pc_reg: PC register with redirect/advance mux and +4 adder; FSM and buffer in fetch_unit.

Verification
REQ-037 Reset release, gnt=1, rvalid 1 cycle later, IF_ID_write=1 -> addresses 0x0,0x4,0x8; fetch_valid every 3rd cycle with matching pc.
REQ-038 IF_ID_write=0 for 5 cycles in HOLD -> fetch_inst/fetch_pc unchanged, imem_req=0, no pc advance.
REQ-039 branch_taken, target 0x103, in WAIT; rvalid 2 cycles later -> data discarded, next imem_addr=0x100, IF_flush=1 that cycle only.
REQ-040 pc=0xFFFF_FFFC consumed -> next imem_addr=0x0, fetch_pc_next=0x0.
REQ-041 branch_taken with IF_ID_write=1 in HOLD, target 0x40 -> next request 0x40, not pc+4.
REQ-042 reset_n low during WAIT, stale rvalid after release -> ignored; first fetch at RESET_PC.
